// File: rtl/arriagx_pll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arriagx_pll_pkg
// Description : Shared definitions for the PLL lock detector: phase-detector
//               state encoding, default tuning constants and a small helper
//               for sizing saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
package arriagx_pll_pkg;

    // Default tuning constants
    localparam int DEF_CNTW      = 16;
    localparam int DEF_TOL       = 2;
    localparam int DEF_LOCK_HIGH = 16;
    localparam int DEF_LOCK_LOW  = 4;
    localparam int DEF_TIMEOUT   = 1023;

    // Phase-detector state encoding (2 bits)
    localparam int                 STATE_W         = 2;
    localparam logic [STATE_W-1:0] ST_IDLE_ENC     = 2'd0;
    localparam logic [STATE_W-1:0] ST_REF_LEAD_ENC = 2'd1;
    localparam logic [STATE_W-1:0] ST_FB_LEAD_ENC  = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_REF_LEAD = ST_REF_LEAD_ENC,
        ST_FB_LEAD  = ST_FB_LEAD_ENC
    } pll_state_t;

    // Bits needed to hold the value max_val (at least 1)
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : arriagx_pll_pkg
`default_nettype wire

// File: rtl/arriagx_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : arriagx_edge_sync
// Description : Two-flop synchronizer followed by a registered rising-edge
//               detector. An input rising edge appears as a one-cycle pulse
//               on rise three clk cycles later.
// Ports       : clk      - sampling clock
//               reset    - synchronous, active-high
//               async_in - signal asynchronous to clk
//               rise     - one-cycle pulse per synchronized rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module arriagx_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync1   <= async_in;
            sync2   <= sync1;
            sync2_d <= sync2;
            rise    <= sync2 & ~sync2_d;
        end
    end

endmodule : arriagx_edge_sync
`default_nettype wire

// File: rtl/arriagx_pll_lock_detect.sv
`default_nettype none
// ============================================================================
// Module      : arriagx_pll_lock_detect
// Description : Digital phase comparator and lock detector for the divided
//               reference (N) and feedback (M) clocks. Both are oversampled
//               on clk; the skew between their rising edges is counted in clk
//               cycles and reported per measurement. Lock asserts after a run
//               of in-tolerance measurements and drops after a run of
//               out-of-tolerance ones.
// Ports       : clk       - sampling clock (>= 8x refclk/fbclk)
//               reset     - synchronous, active-high
//               enable    - low clears everything except the synchronizers
//               refclk    - N-counter output (asynchronous)
//               fbclk     - M-counter output (asynchronous)
//               up        - ref edge seen, fb edge awaited
//               dn        - fb edge seen, ref edge awaited
//               err_valid - one-cycle pulse per completed measurement
//               phase_err - signed skew, positive when fb lags ref
//               locked    - lock indication
// Revision    : 1.0 - initial release
// ============================================================================
module arriagx_pll_lock_detect
    import arriagx_pll_pkg::*;
#(
    parameter int CNTW      = DEF_CNTW,
    parameter int TOL       = DEF_TOL,
    parameter int LOCK_HIGH = DEF_LOCK_HIGH,
    parameter int LOCK_LOW  = DEF_LOCK_LOW,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   refclk,
    input  logic                   fbclk,
    output logic                   up,
    output logic                   dn,
    output logic                   err_valid,
    output logic signed [CNTW-1:0] phase_err,
    output logic                   locked
);

    localparam int            CW        = CNTW - 1;
    localparam int            GW        = cnt_width(LOCK_HIGH);
    localparam int            BW        = cnt_width(LOCK_LOW);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] TOL_C     = CW'(TOL);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [GW-1:0] LOCK_HI_C = GW'(LOCK_HIGH);
    localparam logic [BW-1:0] LOCK_LO_C = BW'(LOCK_LOW);

    logic                   ref_rise;
    logic                   fb_rise;

    pll_state_t             state;
    pll_state_t             nxt_state;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          nxt_cnt;

    logic                   done;        // a measurement completes this cycle
    logic                   forced_bad;  // cycle slip or timeout
    logic                   skew_neg;    // fb led
    logic [CW-1:0]          skew_mag;
    logic signed [CNTW-1:0] skew_val;
    logic                   aligned;

    logic [GW-1:0]          good_cnt;
    logic [GW-1:0]          good_inc;
    logic [BW-1:0]          bad_cnt;
    logic [BW-1:0]          bad_inc;

    arriagx_edge_sync u_ref_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (refclk),
        .rise     (ref_rise)
    );

    arriagx_edge_sync u_fb_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (fbclk),
        .rise     (fb_rise)
    );

    // Measurement decode. In a lead state the "closing" edge is the other
    // clock; a repeat of the leading clock first is a cycle slip. When the
    // closing edge arrives together with a new leading edge, the result is
    // reported and a fresh measurement starts in the same cycle.
    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        done       = 1'b0;
        forced_bad = 1'b0;
        skew_neg   = 1'b0;
        skew_mag   = cnt;
        case (state)
            ST_IDLE: begin
                if (ref_rise && fb_rise) begin
                    done     = 1'b1;
                    skew_mag = '0;
                end else if (ref_rise) begin
                    nxt_state = ST_REF_LEAD;
                    nxt_cnt   = ONE_C;
                end else if (fb_rise) begin
                    nxt_state = ST_FB_LEAD;
                    nxt_cnt   = ONE_C;
                end
            end
            ST_REF_LEAD: begin
                if (fb_rise) begin
                    done = 1'b1;
                    if (ref_rise) begin
                        nxt_cnt = ONE_C;
                    end else begin
                        nxt_state = ST_IDLE;
                        nxt_cnt   = '0;
                    end
                end else if (ref_rise) begin
                    done       = 1'b1;
                    forced_bad = 1'b1;
                    nxt_cnt    = ONE_C;
                end else if (cnt == TIMEOUT_C) begin
                    done       = 1'b1;
                    forced_bad = 1'b1;
                    skew_mag   = TIMEOUT_C;
                    nxt_state  = ST_IDLE;
                    nxt_cnt    = '0;
                end else begin
                    nxt_cnt = cnt + ONE_C;
                end
            end
            ST_FB_LEAD: begin
                skew_neg = 1'b1;
                if (ref_rise) begin
                    done = 1'b1;
                    if (fb_rise) begin
                        nxt_cnt = ONE_C;
                    end else begin
                        nxt_state = ST_IDLE;
                        nxt_cnt   = '0;
                    end
                end else if (fb_rise) begin
                    done       = 1'b1;
                    forced_bad = 1'b1;
                    nxt_cnt    = ONE_C;
                end else if (cnt == TIMEOUT_C) begin
                    done       = 1'b1;
                    forced_bad = 1'b1;
                    skew_mag   = TIMEOUT_C;
                    nxt_state  = ST_IDLE;
                    nxt_cnt    = '0;
                end else begin
                    nxt_cnt = cnt + ONE_C;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        skew_val = signed'({1'b0, skew_mag});
        if (skew_neg) begin
            skew_val = -skew_val;
        end
    end

    assign aligned  = !forced_bad && (skew_mag <= TOL_C);
    assign good_inc = (good_cnt == LOCK_HI_C) ? good_cnt : good_cnt + GW'(1);
    assign bad_inc  = (bad_cnt  == LOCK_LO_C) ? bad_cnt  : bad_cnt  + BW'(1);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            up        <= 1'b0;
            dn        <= 1'b0;
            err_valid <= 1'b0;
            phase_err <= '0;
            locked    <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            up        <= (nxt_state == ST_REF_LEAD);
            dn        <= (nxt_state == ST_FB_LEAD);
            err_valid <= done;
            if (done) begin
                phase_err <= skew_val;
                if (aligned) begin
                    good_cnt <= good_inc;
                    bad_cnt  <= '0;
                    if (good_inc == LOCK_HI_C) begin
                        locked <= 1'b1;
                    end
                end else begin
                    bad_cnt  <= bad_inc;
                    good_cnt <= '0;
                    if (bad_inc == LOCK_LO_C) begin
                        locked <= 1'b0;
                    end
                end
            end
        end
    end

endmodule : arriagx_pll_lock_detect
`default_nettype wire

// File: tb/tb_arriagx_pll_lock_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_arriagx_pll_lock_detect
// Description : Self-checking bench for arriagx_pll_lock_detect. A timestamp
//               based model predicts every output each cycle; directed
//               scenarios add hand-computed expectations on lock timing,
//               skew values and up/dn pulse widths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arriagx_pll_lock_detect;

    localparam int CNTW      = 16;
    localparam int TOL       = 2;
    localparam int LOCK_HIGH = 16;
    localparam int LOCK_LOW  = 4;
    localparam int TIMEOUT   = 1023;

    // Literal-check request kinds
    localparam int K_ZERO    = 1;
    localparam int K_LOCK    = 2;
    localparam int K_LEAD    = 3;
    localparam int K_SLIP    = 4;
    localparam int K_TMO     = 5;
    localparam int K_SIMUL   = 6;
    localparam int K_RSTMID  = 7;
    localparam int K_ENMID   = 8;
    localparam int K_WAITEXP = 9;

    logic                   clk;
    logic                   reset;
    logic                   enable;
    logic                   refclk;
    logic                   fbclk;
    logic                   up;
    logic                   dn;
    logic                   err_valid;
    logic signed [CNTW-1:0] phase_err;
    logic                   locked;

    arriagx_pll_lock_detect #(
        .CNTW      (CNTW),
        .TOL       (TOL),
        .LOCK_HIGH (LOCK_HIGH),
        .LOCK_LOW  (LOCK_LOW),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .refclk    (refclk),
        .fbclk     (fbclk),
        .up        (up),
        .dn        (dn),
        .err_valid (err_valid),
        .phase_err (phase_err),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus-side state (written by stim only) ----------
    int t_cur   = 0;
    int r_per   = 0;
    int r_off   = 0;
    int f_per   = 0;
    int f_off   = 0;
    int phase_id = 0;
    int req_seq  = 0;
    int req_kind = 0;
    bit chk_on   = 1'b0;

    // ---------------- behavioural model (timestamps, unbounded counts) -----
    int  m_cyc = 0;
    bit  rh[5];
    bit  fh[5];
    bit  pend;
    bit  lead_ref;
    int  start_cyc;
    int  run_good;
    int  run_bad;
    bit  m_up, m_dn, m_valid, m_locked;
    int  m_phase;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_clear();
        pend = 0; run_good = 0; run_bad = 0;
        m_up = 0; m_dn = 0; m_valid = 0; m_phase = 0; m_locked = 0;
    endtask

    task automatic model_complete(input int v, input bit may_align);
        m_valid = 1;
        m_phase = v;
        if (may_align && iabs(v) <= TOL) begin
            run_good++; run_bad = 0;
            if (run_good >= LOCK_HIGH) m_locked = 1;
        end else begin
            run_bad++; run_good = 0;
            if (run_bad >= LOCK_LOW) m_locked = 0;
        end
    endtask

    initial model_clear();

    always @(posedge clk) begin
        bit r, f, lead, lag;
        int el, sgn;
        m_cyc++;
        for (int i = 4; i > 0; i--) begin
            rh[i] = rh[i-1];
            fh[i] = fh[i-1];
        end
        rh[0] = refclk;
        fh[0] = fbclk;
        // an input edge is seen by the comparator three samples later
        r = rh[3] & ~rh[4];
        f = fh[3] & ~fh[4];
        if (reset) begin
            model_clear();
            for (int i = 0; i < 3; i++) begin
                rh[i] = 0;
                fh[i] = 0;
            end
        end else if (!enable) begin
            model_clear();
        end else begin
            m_valid = 0;
            if (!pend) begin
                if (r && f) model_complete(0, 1);
                else if (r) begin pend = 1; lead_ref = 1; start_cyc = m_cyc; end
                else if (f) begin pend = 1; lead_ref = 0; start_cyc = m_cyc; end
            end else begin
                lead = lead_ref ? r : f;
                lag  = lead_ref ? f : r;
                sgn  = lead_ref ? 1 : -1;
                el   = m_cyc - start_cyc;
                if (lag) begin
                    model_complete(sgn * el, 1);
                    if (lead) start_cyc = m_cyc;
                    else pend = 0;
                end else if (lead) begin
                    model_complete(sgn * el, 0);
                    start_cyc = m_cyc;
                end else if (el == TIMEOUT) begin
                    model_complete(sgn * TIMEOUT, 0);
                    pend = 0;
                end
            end
            m_up = pend && lead_ref;
            m_dn = pend && !lead_ref;
        end
    end

    // ---------------- compare process ----------------------------------
    int n_vec = 0;
    int n_err = 0;
    int served = 0;
    int cur_phase = -1;
    int nv, first_phase, last_phase, lock_at, fall_at;
    int c0, c1, c3, c32, c1023;
    int up_run, dn_run, last_up_run, last_dn_run, updn_cycles;
    bit saw_locked, prev_locked;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_lit(input int kind);
        case (kind)
            K_ZERO: begin
                chk("zero_up", int'(up), 0);
                chk("zero_dn", int'(dn), 0);
                chk("zero_err_valid", int'(err_valid), 0);
                chk("zero_phase_err", int'(phase_err), 0);
                chk("zero_locked", int'(locked), 0);
            end
            K_LOCK: begin
                chk("lock_at_valid", lock_at, 16);
                chk("lock_up_width", last_up_run, 1);
                chk("lock_all_plus1", c1, nv);
                chk("lock_last_phase", last_phase, 1);
            end
            K_LEAD: begin
                chk("lead_fall_at_valid", fall_at, 4);
                chk("lead_last_phase", last_phase, -5);
                chk("lead_dn_width", last_dn_run, 5);
                chk("lead_locked", int'(locked), 0);
            end
            K_SLIP: begin
                chk("slip_never_locked", int'(saw_locked), 0);
                chk("slip_saw_plus3", int'(c3 > 0), 1);
                chk("slip_saw_plus32", int'(c32 > 0), 1);
                chk("slip_only_3_32", c3 + c32, nv);
            end
            K_TMO: begin
                chk("tmo_count", c1023, 3);
                chk("tmo_valids", nv, 3);
                chk("tmo_never_locked", int'(saw_locked), 0);
            end
            K_SIMUL: begin
                chk("simul_lock_at", lock_at, 16);
                chk("simul_updn_cycles", updn_cycles, 0);
                chk("simul_all_zero", c0, nv);
            end
            K_RSTMID: begin
                chk("rstmid_first_phase", first_phase, 0);
                chk("rstmid_lock_at", lock_at, 16);
            end
            K_ENMID: begin
                chk("enmid_first_phase", first_phase, -30);
                chk("enmid_never_locked", int'(saw_locked), 0);
            end
            K_WAITEXP: chk("wait_up_bound", 0, 1);
            default: chk("unknown_request", kind, 0);
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (phase_id != cur_phase) begin
                cur_phase = phase_id;
                nv = 0; first_phase = 0; last_phase = 0; lock_at = -1; fall_at = -1;
                c0 = 0; c1 = 0; c3 = 0; c32 = 0; c1023 = 0;
                up_run = 0; dn_run = 0; last_up_run = 0; last_dn_run = 0;
                updn_cycles = 0; saw_locked = 0;
            end
            chk("up", int'(up), int'(m_up));
            chk("dn", int'(dn), int'(m_dn));
            chk("err_valid", int'(err_valid), int'(m_valid));
            chk("phase_err", int'(phase_err), m_phase);
            chk("locked", int'(locked), int'(m_locked));

            if (err_valid) begin
                nv++;
                if (nv == 1) first_phase = int'(phase_err);
                last_phase = int'(phase_err);
                if (phase_err == 0)    c0++;
                if (phase_err == 1)    c1++;
                if (phase_err == 3)    c3++;
                if (phase_err == 32)   c32++;
                if (phase_err == 1023) c1023++;
            end
            if (locked && lock_at < 0) lock_at = nv;
            if (!locked && prev_locked && fall_at < 0) fall_at = nv;
            prev_locked = locked;
            if (locked) saw_locked = 1;
            if (up) up_run++;
            else if (up_run > 0) begin last_up_run = up_run; up_run = 0; end
            if (dn) dn_run++;
            else if (dn_run > 0) begin last_dn_run = dn_run; dn_run = 0; end
            if (up || dn) updn_cycles++;

            if (req_seq != served) begin
                served = req_seq;
                do_lit(req_kind);
            end
        end
    end

    // ---------------- stimulus ------------------------------------------
    function automatic logic wave(input int t, input int p, input int o);
        if (p == 0) return 1'b0;
        return ((((t - o) % p) + p) % p) < (p / 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        t_cur++;
        refclk = wave(t_cur, r_per, r_off);
        fbclk  = wave(t_cur, f_per, f_off);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic request(input int kind);
        req_kind = kind;
        req_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        r_per = 0;
        f_per = 0;
        run(4);
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        t_cur = 0;
    endtask

    task automatic wait_up(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            @(negedge clk);
            if (up) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        reset  = 1'b1;
        enable = 1'b1;
        refclk = 1'b0;
        fbclk  = 1'b0;
        run(2);
        chk_on = 1'b1;
        run(3);
        reset = 1'b0;
        request(K_ZERO);

        // lock: fb lags ref by one cycle
        do_reset();
        phase_id = 2;
        r_per = 32; r_off = 4; f_per = 32; f_off = 5;
        run(640);
        request(K_LOCK);

        // fb jumps to lead by five cycles
        phase_id = 3;
        f_off = -1;
        run(256);
        request(K_LEAD);

        // cycle slip: fb at half the ref rate, lagging 3
        do_reset();
        phase_id = 4;
        r_per = 32; r_off = 4; f_per = 64; f_off = 7;
        run(640);
        request(K_SLIP);

        // timeout: fb stuck low
        do_reset();
        phase_id = 5;
        r_per = 2400; r_off = 4; f_per = 0; f_off = 0;
        run(6000);
        request(K_TMO);

        // identical waveforms
        do_reset();
        phase_id = 6;
        r_per = 32; r_off = 4; f_per = 32; f_off = 4;
        run(640);
        request(K_SIMUL);

        // reset pulse while REF_LEAD (fb lags 2)
        do_reset();
        phase_id = 7;
        r_per = 32; r_off = 4; f_per = 32; f_off = 6;
        run(160);
        wait_up(ok);
        if (!ok) request(K_WAITEXP);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        phase_id = 8;
        request(K_ZERO);
        run(640);
        request(K_RSTMID);

        // enable drop while REF_LEAD (fb lags 2)
        do_reset();
        phase_id = 9;
        r_per = 32; r_off = 4; f_per = 32; f_off = 6;
        run(160);
        wait_up(ok);
        if (!ok) request(K_WAITEXP);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        phase_id = 10;
        request(K_ZERO);
        run(200);
        request(K_ENMID);

        run(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_arriagx_pll_lock_detect
`default_nettype wire
